// File: rtl/order_tx_framer_if.sv
// order_tx_framer_if: record-in and byte-out valid/ready links.
// master drives records and tx_ready; slave is the framer.
interface order_tx_framer_if;
   logic [7:0]  in_type;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic        tx_ready;

   modport master (
      output in_type,
      output in_data,
      output in_valid,
      input  in_ready,
      input  tx_byte,
      input  tx_valid,
      output tx_ready
   );

   modport slave (
      input  in_type,
      input  in_data,
      input  in_valid,
      output in_ready,
      output tx_byte,
      output tx_valid,
      input  tx_ready
   );
endinterface

// File: rtl/order_tx_framer.sv
// order_tx_framer: frames decision records as SOF,type,data[31:0]
// MSB-first,[lat16],xor-csum onto a byte valid/ready link.
// Ports: clk, rst (async, active-high); link (slave: in_type,
// in_data, in_valid, in_ready, tx_byte, tx_valid, tx_ready);
// cycle_cnt, t_ingress (latency tag only); busy; frames_sent.
// Option: LATENCY_TAG_EN adds two saturated latency bytes.
module order_tx_framer #(
   parameter logic [7:0] SOF_BYTE = 8'hA5,
   parameter int         CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   order_tx_framer_if.slave link,
   input  logic [31:0]      cycle_cnt,
   input  logic [31:0]      t_ingress,
   output logic             busy,
   output logic [CNT_W-1:0] frames_sent
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SOF,
      S_TYPE,
      S_DATA,
      S_LAT,
      S_CSUM
   } state_t;

   state_t state_q, state_d;

   logic [1:0]       idx_q, idx_d;
   logic [7:0]       type_q, type_d;
   logic [31:0]      data_q, data_d;
   logic [7:0]       csum_q, csum_d;
   logic [7:0]       tx_byte_q, tx_byte_d;
   logic             tx_valid_q, tx_valid_d;
   logic [CNT_W-1:0] frames_q, frames_d;

   logic hs;
   logic accept;
   logic in_ready;

`ifdef LATENCY_TAG_EN
   logic [15:0] lat_q, lat_d;
   logic [31:0] lat32;
   logic [15:0] lat16;

   // Unsigned subtraction wraps naturally, so a counter
   // rollover between ingress and accept still measures right.
   assign lat32 = cycle_cnt - t_ingress;
   assign lat16 = (lat32 > 32'h0000_FFFF) ? 16'hFFFF
                                          : lat32[15:0];
`else
   logic unused_lat;
   assign unused_lat = ^{cycle_cnt, t_ingress};
`endif

   // in_ready depends only on state so upstream never sees
   // a combinational path from in_valid back to in_ready.
   assign in_ready = (state_q == S_IDLE) && !rst;
   assign hs       = tx_valid_q && link.tx_ready;
   assign accept   = link.in_valid && in_ready;

   assign link.in_ready = in_ready;
   assign link.tx_byte  = tx_byte_q;
   assign link.tx_valid = tx_valid_q;
   assign busy          = (state_q != S_IDLE);
   assign frames_sent   = frames_q;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      type_d     = type_q;
      data_d     = data_q;
      csum_d     = csum_q;
      tx_byte_d  = tx_byte_q;
      tx_valid_d = tx_valid_q;
      frames_d   = frames_q;
`ifdef LATENCY_TAG_EN
      lat_d      = lat_q;
`endif

      // tx_byte_d is always the byte of the state being
      // entered, so the output register leads the state.
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               type_d     = link.in_type;
               data_d     = link.in_data;
               csum_d     = 8'h00;
`ifdef LATENCY_TAG_EN
               lat_d      = lat16;
`endif
               state_d    = S_SOF;
               tx_byte_d  = SOF_BYTE;
               tx_valid_d = 1'b1;
            end
         end

         S_SOF: begin
            if (hs) begin
               state_d   = S_TYPE;
               tx_byte_d = type_q;
            end
         end

         S_TYPE: begin
            if (hs) begin
               csum_d    = csum_q ^ tx_byte_q;
               state_d   = S_DATA;
               idx_d     = 2'd3;
               tx_byte_d = data_q[31:24];
            end
         end

         S_DATA: begin
            if (hs) begin
               csum_d = csum_q ^ tx_byte_q;
               if (idx_q == 2'd0) begin
`ifdef LATENCY_TAG_EN
                  state_d   = S_LAT;
                  idx_d     = 2'd1;
                  tx_byte_d = lat_q[15:8];
`else
                  state_d   = S_CSUM;
                  tx_byte_d = csum_d;
`endif
               end else begin
                  idx_d     = idx_q - 2'd1;
                  tx_byte_d = data_q[{idx_d, 3'b000} +: 8];
               end
            end
         end

`ifdef LATENCY_TAG_EN
         S_LAT: begin
            if (hs) begin
               csum_d = csum_q ^ tx_byte_q;
               if (idx_q == 2'd0) begin
                  state_d   = S_CSUM;
                  tx_byte_d = csum_d;
               end else begin
                  idx_d     = 2'd0;
                  tx_byte_d = lat_q[7:0];
               end
            end
         end
`endif

         S_CSUM: begin
            if (hs) begin
               state_d    = S_IDLE;
               tx_valid_d = 1'b0;
               frames_d   = frames_q + CNT_W'(1);
            end
         end

         default: begin
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= 2'd0;
         type_q     <= 8'h00;
         data_q     <= 32'h0;
         csum_q     <= 8'h00;
         tx_byte_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         frames_q   <= '0;
`ifdef LATENCY_TAG_EN
         lat_q      <= 16'h0;
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         type_q     <= type_d;
         data_q     <= data_d;
         csum_q     <= csum_d;
         tx_byte_q  <= tx_byte_d;
         tx_valid_q <= tx_valid_d;
         frames_q   <= frames_d;
`ifdef LATENCY_TAG_EN
         lat_q      <= lat_d;
`endif
      end
   end

endmodule

// File: tb/tb_order_tx_framer.sv
// tb_order_tx_framer: directed frames plus randomized traffic
// checked against a queue-based frame model.
module tb_order_tx_framer;

   localparam int CNT_W = 16;
`ifdef LATENCY_TAG_EN
   localparam int FLEN = 9;
`else
   localparam int FLEN = 7;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [31:0]      cycle_cnt;
   logic [31:0]      t_ingress;
   logic             busy;
   logic [CNT_W-1:0] frames_sent;

   order_tx_framer_if bus ();

   order_tx_framer dut (
      .clk         (clk),
      .rst         (rst),
      .link        (bus.slave),
      .cycle_cnt   (cycle_cnt),
      .t_ingress   (t_ingress),
      .busy        (busy),
      .frames_sent (frames_sent)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]       exp_q[$];
   logic [7:0]       log_q[$];
   logic [7:0]       want[$];
   logic [CNT_W-1:0] exp_frames = '0;
   bit               stall_prev = 1'b0;
   logic [7:0]       prev_byte  = 8'h00;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   // Whole frame as the link should carry it.
   function automatic void push_frame(input logic [7:0]  t,
                                      input logic [31:0] d,
                                      input logic [31:0] cc,
                                      input logic [31:0] ti);
      logic [7:0]  body[$];
      logic [7:0]  cs;
      logic [31:0] lat;
      logic [15:0] l16;
      cs   = 8'h00;
      lat  = cc - ti;
      l16  = (lat > 32'hFFFF) ? 16'hFFFF : lat[15:0];
      body = '{t, d[31:24], d[23:16], d[15:8], d[7:0]};
`ifdef LATENCY_TAG_EN
      body.push_back(l16[15:8]);
      body.push_back(l16[7:0]);
`endif
      foreach (body[i]) cs ^= body[i];
      exp_q.push_back(8'hA5);
      foreach (body[i]) exp_q.push_back(body[i]);
      exp_q.push_back(cs);
   endfunction

   // Check outputs at the sample point, then cross one edge.
   task automatic tick(output bit acc);
      bit          hs;
      bit          act;
      logic [7:0]  s_t;
      logic [31:0] s_d, s_cc, s_ti;
      act = (exp_q.size() != 0);
      check("tx_valid", bus.tx_valid, act);
      check("busy", busy, act);
      check("in_ready", bus.in_ready, !act);
      check("frames_sent", frames_sent, exp_frames);
      if (act) check("tx_byte", bus.tx_byte, exp_q[0]);
      if (stall_prev)
         check("stall_hold", bus.tx_byte, prev_byte);
      hs         = act && bus.tx_ready;
      acc        = bus.in_valid && !act;
      stall_prev = act && !bus.tx_ready;
      prev_byte  = bus.tx_byte;
      s_t  = bus.in_type;
      s_d  = bus.in_data;
      s_cc = cycle_cnt;
      s_ti = t_ingress;
      if (hs) log_q.push_back(bus.tx_byte);
      @(posedge clk);
      if (hs) begin
         void'(exp_q.pop_front());
         if (exp_q.size() == 0) exp_frames++;
      end
      if (acc) push_frame(s_t, s_d, s_cc, s_ti);
      #1;
   endtask

   task automatic drain(input int mode);
      bit acc;
      for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
         bus.tx_ready = (mode == 0) ? 1'b1 : ((i % 2) == 0);
         tick(acc);
      end
      if (exp_q.size() != 0)
         check("drain_timeout", exp_q.size(), 0);
   endtask

   task automatic send_frame(input logic [7:0]  t,
                             input logic [31:0] d,
                             input logic [31:0] cc,
                             input logic [31:0] ti,
                             input int          mode);
      bit acc;
      log_q.delete();
      bus.in_type  = t;
      bus.in_data  = d;
      cycle_cnt    = cc;
      t_ingress    = ti;
      bus.in_valid = 1'b1;
      bus.tx_ready = 1'b1;
      tick(acc);
      check("accept", acc, 1);
      bus.in_valid = 1'b0;
      drain(mode);
   endtask

   task automatic check_log(input string tag);
      check({tag, "_len"}, log_q.size(), want.size());
      for (int i = 0; i < want.size() && i < log_q.size(); i++)
         check($sformatf("%s_b%0d", tag, i), log_q[i], want[i]);
   endtask

   initial begin
      bit acc;
      int k;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_type  = 8'h00;
      bus.in_data  = 32'h0;
      bus.tx_ready = 1'b0;
      cycle_cnt    = 32'h0;
      t_ingress    = 32'h0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_valid", bus.tx_valid, 0);
      check("rst_tx_byte", bus.tx_byte, 0);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_frames", frames_sent, 0);
      rst = 1'b0;
      #1;

      // Reference record, full-rate.
`ifdef LATENCY_TAG_EN
      want = '{8'hA5, 8'h42, 8'h11, 8'h22, 8'h33,
               8'h44, 8'h00, 8'h20, 8'h26};
`else
      want = '{8'hA5, 8'h42, 8'h11, 8'h22, 8'h33,
               8'h44, 8'h06};
`endif
      send_frame(8'h42, 32'h11223344, 32'h120, 32'h100, 0);
      check_log("t1");
      check("t1_frames", frames_sent, 1);

      // Same record with tx_ready toggling.
      send_frame(8'h42, 32'h11223344, 32'h120, 32'h100, 1);
      check_log("t2");

`ifdef LATENCY_TAG_EN
      want = '{8'hA5, 8'h42, 8'h11, 8'h22, 8'h33,
               8'h44, 8'h00, 8'h15, 8'h13};
      send_frame(8'h42, 32'h11223344, 32'h5,
                 32'hFFFF_FFF0, 0);
      check_log("wrap");
      want = '{8'hA5, 8'h42, 8'h11, 8'h22, 8'h33,
               8'h44, 8'hFF, 8'hFF, 8'h06};
      send_frame(8'h42, 32'h11223344, 32'h2_0100,
                 32'h100, 0);
      check_log("sat");
`endif

      // Second record held while the first is in flight.
      bus.in_type  = 8'h01;
      bus.in_data  = 32'hDEADBEEF;
      cycle_cnt    = 32'h30;
      t_ingress    = 32'h10;
      bus.in_valid = 1'b1;
      bus.tx_ready = 1'b1;
      tick(acc);
      check("bb_accept1", acc, 1);
      bus.in_type = 8'h02;
      bus.in_data = 32'hCAFEF00D;
      acc = 1'b0;
      k   = 0;
      while (!acc && k < 40) begin
         k++;
         tick(acc);
      end
      check("bb_period", k, FLEN + 1);
      bus.in_valid = 1'b0;
      drain(0);

      // Reset in the middle of a frame.
      bus.in_type  = 8'h42;
      bus.in_data  = 32'h11223344;
      bus.in_valid = 1'b1;
      bus.tx_ready = 1'b1;
      tick(acc);
      bus.in_valid = 1'b0;
      repeat (3) tick(acc);
      rst = 1'b1;
      #1;
      check("mid_rst_tx_valid", bus.tx_valid, 0);
      check("mid_rst_in_ready", bus.in_ready, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_frames", frames_sent, 0);
      exp_q.delete();
      exp_frames = '0;
      stall_prev = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      repeat (4) tick(acc);

      // Random traffic.
      for (int c = 0; c < 1500; c++) begin
         if (!bus.in_valid && $urandom_range(0, 2) == 0) begin
            bus.in_type  = 8'($urandom);
            bus.in_data  = $urandom;
            t_ingress    = $urandom;
            case ($urandom_range(0, 2))
               0: cycle_cnt = t_ingress + $urandom_range(0, 300);
               1: cycle_cnt = t_ingress +
                              $urandom_range(32'hFF00, 32'h1_0100);
               default: cycle_cnt = $urandom;
            endcase
            bus.in_valid = 1'b1;
         end
         bus.tx_ready = ($urandom_range(0, 3) != 0);
         tick(acc);
         if (acc) bus.in_valid = 1'b0;
      end
      bus.in_valid = 1'b0;
      drain(0);
      tick(acc);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
